// File: rtl/intr_ctrl_if.sv
// Register window between the CPU-side bus master and the interrupt controller.
interface intr_ctrl_if;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_we, reg_re, reg_addr, reg_wdata, input  reg_rdata);
  modport slave  (input  reg_we, reg_re, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: per-source sync/gateway, priority/threshold arbiter, claim/complete FSM.
// Build option INTR_TIMEOUT_EN: re-notify after TIMEOUT_CYC unclaimed cycles in WAIT_CLAIM.
// Source ID i (1..NUM_SRC) is line src_i[i-1] and bit i of PENDING/ENABLE/EDGE.

module intr_gw (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic edge_mode,
  input  logic block,
  input  logic clr,
  output logic pend_q
);
  logic [2:0] sync_q;  // [0],[1] synchroniser, [2] previous value for edge detect
  logic       set;

  assign set = (edge_mode ? (sync_q[1] & ~sync_q[2]) : sync_q[1]) & ~block;

  // set beats clear so an edge coinciding with a claim read is never lost
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= '0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], src_i};
      pend_q <= (pend_q & ~clr) | set;
    end
endmodule

module intr_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int PRIO_W      = 3,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               mie_i,
  intr_ctrl_if.slave         bus,
  output logic               e_intr_o,
  output logic [ID_W-1:0]    claim_id_o
);
  localparam logic [7:0] A_PEND = 8'h00, A_EN = 8'h04, A_THR = 8'h08,
                         A_CLAIM = 8'h0C, A_EDGE = 8'h10;

  if ((1 << ID_W) <= NUM_SRC || TIMEOUT_CYC < 2) begin : g_cfg_err
    $error("intr_ctrl: ID_W too narrow for NUM_SRC or TIMEOUT_CYC < 2");
  end

  typedef enum logic [1:0] {IDLE, NOTIFY, WAIT_CLAIM, SERVICE} state_t;
  state_t state_q, state_d;

  logic [NUM_SRC:1]             pend, en_q, edge_q, gw_block, gw_clr, prio_sel;
  logic [NUM_SRC:1][PRIO_W-1:0] prio_q;
  logic [PRIO_W-1:0]            thr_q, best_prio;
  logic [ID_W-1:0]              best_id;
  logic                         claim_rd, claim_take, complete, to_hit;

  assign claim_rd = bus.reg_re && (bus.reg_addr == A_CLAIM);

  for (genvar i = 1; i <= NUM_SRC; i++) begin : g_src
    assign prio_sel[i] = (bus.reg_addr == 8'(28 + 4*i));
    // gateway stays shut for the source in service and the one being claimed now
    assign gw_block[i] = (claim_id_o == ID_W'(i)) || (claim_take && best_id == ID_W'(i));
    assign gw_clr[i]   = claim_rd && (best_id == ID_W'(i));
    intr_gw u_gw (
      .clk_i, .rst_ni,
      .src_i     (src_i[i-1]),
      .edge_mode (edge_q[i]),
      .block     (gw_block[i]),
      .clr       (gw_clr[i]),
      .pend_q    (pend[i])
    );
  end

  // strict '>' while scanning upward leaves ties with the lowest ID
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++)
      if (pend[i] && en_q[i] && prio_q[i] > thr_q && prio_q[i] > best_prio) begin
        best_id   = ID_W'(i);
        best_prio = prio_q[i];
      end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      en_q   <= '0;
      edge_q <= '0;
      thr_q  <= '0;
      prio_q <= '0;
    end else if (bus.reg_we) begin
      if (bus.reg_addr == A_EN)   en_q   <= bus.reg_wdata[NUM_SRC:1];
      if (bus.reg_addr == A_EDGE) edge_q <= bus.reg_wdata[NUM_SRC:1];
      if (bus.reg_addr == A_THR)  thr_q  <= bus.reg_wdata[PRIO_W-1:0];
      for (int i = 1; i <= NUM_SRC; i++)
        if (prio_sel[i]) prio_q[i] <= bus.reg_wdata[PRIO_W-1:0];
    end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      A_PEND:  bus.reg_rdata = 32'({pend, 1'b0});
      A_EN:    bus.reg_rdata = 32'({en_q, 1'b0});
      A_THR:   bus.reg_rdata = 32'(thr_q);
      A_CLAIM: bus.reg_rdata = 32'(best_id);
      A_EDGE:  bus.reg_rdata = 32'({edge_q, 1'b0});
      default:
        for (int i = 1; i <= NUM_SRC; i++)
          if (prio_sel[i]) bus.reg_rdata = 32'(prio_q[i]);
    endcase
  end

`ifdef INTR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // zero on the first WAIT_CLAIM cycle, since every other state holds it cleared
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)                  to_cnt_q <= '0;
    else if (state_q != WAIT_CLAIM) to_cnt_q <= '0;
    else                          to_cnt_q <= to_cnt_q + 1'b1;

  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (best_id != '0 && mie_i) state_d = NOTIFY;
      NOTIFY:     if (claim_rd) state_d = (best_id != '0) ? SERVICE : IDLE;
                  else          state_d = WAIT_CLAIM;
      WAIT_CLAIM: if (claim_rd) state_d = (best_id != '0) ? SERVICE : IDLE;
                  else if (to_hit) state_d = NOTIFY;
      SERVICE:    if (complete) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    e_intr_o   = 1'b0;
    claim_take = 1'b0;
    complete   = 1'b0;
    case (state_q)
      NOTIFY: begin
        e_intr_o   = 1'b1;
        claim_take = claim_rd && (best_id != '0);
      end
      WAIT_CLAIM: claim_take = claim_rd && (best_id != '0);
      SERVICE:    complete   = bus.reg_we && (bus.reg_addr == A_CLAIM) &&
                               (bus.reg_wdata == 32'(claim_id_o));
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)         claim_id_o <= '0;
    else if (claim_take) claim_id_o <= best_id;
    else if (complete)   claim_id_o <= '0;
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: register table, directed sequences, random claim order.
module tb_intr_ctrl;
  localparam int NS = 8, PW = 3, IW = 4, TO = 16;

  logic          clk = 1'b0, rst_n = 1'b0, mie = 1'b0;
  logic [NS-1:0] src = '0;
  logic          e_intr;
  logic [IW-1:0] claim_id;

  intr_ctrl_if bus();

  intr_ctrl #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .mie_i(mie), .bus(bus),
    .e_intr_o(e_intr), .claim_id_o(claim_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  // model state: priorities, enable, threshold, pending per ID
  int mprio [1:NS];
  bit men   [1:NS];
  bit mpend [1:NS];
  int mthr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk); bus.reg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); bus.reg_re = 1'b1; bus.reg_addr = a; #1 d = bus.reg_rdata;
    @(negedge clk); bus.reg_re = 1'b0;
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    @(negedge clk); src = src | m;
    @(negedge clk); src = src & ~m;
  endtask

  task automatic wait_intr(input string nm, input int lim);
    bit seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk); seen = e_intr;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic count_pulses(input int cyc, output int cnt);
    cnt = 0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk); if (e_intr) cnt++;
    end
  endtask

  function automatic int model_best();
    int key, best_key, id;
    best_key = -1; id = 0;
    for (int i = 1; i <= NS; i++)
      if (mpend[i] && men[i] && mprio[i] > mthr) begin
        key = mprio[i] * 100 + (NS - i);  // priority dominates, lower ID wins ties
        if (key > best_key) begin best_key = key; id = i; end
      end
    return id;
  endfunction

  function automatic logic [31:0] model_pend_word();
    logic [31:0] w = '0;
    for (int i = 1; i <= NS; i++) w[i] = mpend[i];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] d, enw;
    int          first, hi, cnt, p1, p2, exp_id;
    int          ids[3];

    bus.reg_we = 1'b0; bus.reg_re = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk("rst_eintr", 32'(e_intr), 0);
    chk("rst_claim_id", 32'(claim_id), 0);
    chk("rst_rdata", bus.reg_rdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // register table: reset reads, then write/readback incl. masking and unmapped space
    tbl = '{
      '{1'b0, 8'h00, 32'h0,        32'h0},
      '{1'b0, 8'h04, 32'h0,        32'h0},
      '{1'b0, 8'h08, 32'h0,        32'h0},
      '{1'b0, 8'h0C, 32'h0,        32'h0},
      '{1'b0, 8'h10, 32'h0,        32'h0},
      '{1'b0, 8'h2C, 32'h0,        32'h0},
      '{1'b1, 8'h04, 32'hFFFFFFFF, 32'h1FE},
      '{1'b1, 8'h08, 32'h000000FF, 32'h7},
      '{1'b1, 8'h10, 32'h12345678, 32'h078},
      '{1'b1, 8'h20, 32'h0000000D, 32'h5},
      '{1'b1, 8'h3C, 32'h00000006, 32'h6},
      '{1'b1, 8'h40, 32'h00000007, 32'h0},
      '{1'b1, 8'h22, 32'h00000003, 32'h0},
      '{1'b1, 8'h00, 32'h000000FF, 32'h0},
      '{1'b1, 8'h80, 32'hFFFFFFFF, 32'h0}
    };
    foreach (tbl[k]) begin
      if (tbl[k].we) wr(tbl[k].addr, tbl[k].wdata);
      rd(tbl[k].addr, d);
      chk($sformatf("reg_%02h", tbl[k].addr), d, tbl[k].exp);
    end
    wr(8'h04, 0); wr(8'h08, 0); wr(8'h20, 0); wr(8'h3C, 0);
    wr(8'h10, 32'h1FE);

    // edge notify and claim: ID3 prio 2
    wr(8'h28, 2); wr(8'h04, 32'h08); mie = 1'b1;
    @(negedge clk); src[2] = 1'b1;
    first = -1; hi = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) src[2] = 1'b0;
      if (e_intr) begin if (first < 0) first = k; hi++; end
    end
    chk("notify_latency", 32'(first), 4);
    chk("notify_width", 32'(hi), 1);
    rd(8'h00, d); chk("pend_before_claim", d, 32'h08);
    rd(8'h0C, d); chk("claim_id3", d, 3);
    rd(8'h00, d); chk("pend_after_claim", d, 0);
    chk("claim_id_o_3", 32'(claim_id), 3);
    wr(8'h0C, 3); chk("complete_3", 32'(claim_id), 0);

    // priority and tie-break
    wr(8'h24, 4); wr(8'h30, 4); wr(8'h34, 5); wr(8'h04, 32'h64);
    pulse(8'b0011_0010);
    ids = '{6, 2, 5};
    foreach (ids[k]) begin
      wait_intr($sformatf("prio_notify_%0d", k), 10);
      rd(8'h0C, d); chk($sformatf("prio_claim_%0d", k), d, 32'(ids[k]));
      wr(8'h0C, 32'(ids[k]));
    end

    // threshold and mask
    wr(8'h08, 4); wr(8'h20, 4); wr(8'h04, 32'h02);
    pulse(8'h01);
    count_pulses(10, cnt); chk("thr_blocks", 32'(cnt), 0);
    rd(8'h00, d); chk("thr_pending", d, 32'h02);
    wr(8'h08, 3);
    wait_intr("thr_lowered", 10);
    rd(8'h0C, d); chk("thr_claim", d, 1);
    wr(8'h0C, 1);
    mie = 1'b0;
    pulse(8'h01);
    count_pulses(10, cnt); chk("mie_blocks", 32'(cnt), 0);
    mie = 1'b1;
    wait_intr("mie_set", 10);
    rd(8'h0C, d); chk("mie_claim", d, 1);
    wr(8'h0C, 1);

    // level re-trigger on ID2 (prio 4 > thr 3)
    wr(8'h10, 32'h1FA); wr(8'h04, 32'h04);
    @(negedge clk); src[1] = 1'b1;
    wait_intr("lvl_notify1", 10);
    rd(8'h0C, d); chk("lvl_claim1", d, 2);
    @(negedge clk); bus.reg_we = 1'b1; bus.reg_addr = 8'h0C; bus.reg_wdata = 2;
    @(negedge clk); bus.reg_we = 1'b0; bus.reg_addr = 8'h00;
    #1 chk("lvl_pend_at_complete", bus.reg_rdata, 0);
    chk("lvl_completed", 32'(claim_id), 0);
    @(negedge clk); #1 chk("lvl_pend_reset", bus.reg_rdata, 32'h04);
    wait_intr("lvl_notify2", 10);
    src[1] = 1'b0;
    rd(8'h0C, d); chk("lvl_claim2", d, 2);
    repeat (5) @(negedge clk);
    wr(8'h0C, 2);
    repeat (4) @(negedge clk);
    rd(8'h00, d); chk("lvl_pend_clear", d, 0);
    wr(8'h10, 32'h1FE);

    // gateway, bad complete, async reset in SERVICE
    wr(8'h08, 0); wr(8'h04, 32'h08);
    pulse(8'h04);
    wait_intr("gw_notify", 10);
    rd(8'h0C, d); chk("gw_claim", d, 3);
    pulse(8'h04);
    repeat (5) @(negedge clk);
    rd(8'h00, d); chk("gw_pend_blocked", d, 0);
    wr(8'h0C, 5); chk("bad_complete", 32'(claim_id), 3);
    @(negedge clk); bus.reg_addr = 8'h04; #2 rst_n = 1'b0;
    #1 chk("arst_claim_id", 32'(claim_id), 0);
    chk("arst_eintr", 32'(e_intr), 0);
    chk("arst_rdata", bus.reg_rdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // re-notify timeout (ID4)
    wr(8'h10, 32'h1FE); wr(8'h2C, 3); wr(8'h04, 32'h10);
    pulse(8'h08);
    p1 = -1; p2 = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (e_intr) begin if (p1 < 0) p1 = k; else if (p2 < 0) p2 = k; end
    end
`ifdef INTR_TIMEOUT_EN
    chk("timeout_gap", 32'(p2 - p1), 32'd17);
`else
    chk("no_renotify", 32'(p2), 32'hFFFFFFFF);
`endif
    rd(8'h0C, d); chk("to_claim", d, 4);
    wr(8'h0C, 4);

    // random programming and pulses against the model
    for (int i = 1; i <= NS; i++) mpend[i] = 1'b0;
    for (int it = 0; it < 30; it++) begin
      mie = 1'b0;
      for (int i = 1; i <= NS; i++) begin
        mprio[i] = $urandom_range(0, 7);
        wr(8'(28 + 4*i), 32'(mprio[i]));
      end
      enw = '0;
      for (int i = 1; i <= NS; i++) begin
        men[i] = 1'($urandom_range(0, 1)); enw[i] = men[i];
      end
      wr(8'h04, enw);
      mthr = $urandom_range(0, 3);
      wr(8'h08, 32'(mthr));
      d = 32'($urandom_range(0, 255));
      pulse(d[NS-1:0]);
      for (int i = 1; i <= NS; i++) if (d[i-1]) mpend[i] = 1'b1;
      repeat (3) @(negedge clk);
      mie = 1'b1;
      exp_id = model_best();
      if (exp_id == 0) begin
        count_pulses(8, cnt); chk("rnd_quiet", 32'(cnt), 0);
      end
      while (exp_id != 0) begin
        wait_intr("rnd_notify", 10);
        rd(8'h0C, d); chk("rnd_claim", d, 32'(exp_id));
        mpend[exp_id] = 1'b0;
        wr(8'h0C, 32'(exp_id));
        exp_id = model_best();
      end
      rd(8'h00, d); chk("rnd_pending", d, model_pend_word());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller sitting directly upstream of the CPU's CSR register file.
- Synchronises NUM_SRC peripheral interrupt lines and latches them into pending bits through per-source gateways.
- Arbitrates by programmable priority and threshold, then drives the single-cycle external-interrupt strobe the CSR block consumes to set MEIP, mepc and mcause.
- Software claims and completes interrupts through a small memory-mapped register window.

Parameters:
- NUM_SRC, 8, number of interrupt sources; IDs 1..NUM_SRC, ID 0 = none.
- PRIO_W, 3, priority field width; priority 0 = never interrupts.
- ID_W, 4, width of claim/complete ID; must satisfy 2^ID_W > NUM_SRC.
- TIMEOUT_CYC, 1024, re-notify interval, used only with INTR_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- src_i  in  NUM_SRC  raw peripheral interrupt lines, asynchronous.
- mie_i  in  1  global enable, mstatus.MIE from the CSR block.
- reg_we  in  1  register write strobe.
- reg_re  in  1  register read strobe.
- reg_addr  in  8  byte address.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, combinational from reg_addr.
- e_intr_o  out  1  interrupt strobe to the CSR file, one cycle wide.
- claim_id_o  out  ID_W  ID currently in service, 0 if none.

Behaviour:
- Reset: all registers, pending, enable, threshold, priority and FSM state clear. e_intr_o=0, claim_id_o=0, reg_rdata=0.
- Synchroniser: 2-flop synchroniser per source. Source-to-pending latency is 3 cycles.
- EDGE register (bit i=1 means edge mode):
  - Edge mode: a rising edge of the synchronised line sets pending[i].
  - Level mode: pending[i] is set while the synchronised line is high.
- Gateway: a source that is claimed but not yet completed cannot re-set its pending bit; its edges are dropped.
- Register map (32-bit):
  - 0x00 PENDING, read-only.
  - 0x04 ENABLE, read/write.
  - 0x08 THRESHOLD, read/write, bits [PRIO_W-1:0].
  - 0x0C CLAIM/COMPLETE.
  - 0x10 EDGE, read/write.
  - 0x20+4*(i-1) PRIORITY[i], read/write.
  - Unmapped reads return 0; unmapped writes are ignored.
- Arbitration (combinational):
  - Candidate = pending & enable & (priority > threshold).
  - Winner = highest priority; ties go to the lowest ID.
  - best_id = 0 when there is no candidate.
- FSM states IDLE, NOTIFY, WAIT_CLAIM, SERVICE:
  - IDLE -> NOTIFY when best_id!=0 and mie_i=1.
  - NOTIFY: e_intr_o=1 for exactly one cycle, then -> WAIT_CLAIM.
  - WAIT_CLAIM: a reg_re to 0x0C returns best_id, clears pending[best_id], sets claim_id_o=best_id, then -> SERVICE. If best_id=0 at claim time (source disabled meanwhile), return 0 and go -> IDLE.
  - SERVICE: a reg_we to 0x0C with wdata==claim_id_o completes: claim_id_o=0, gateway reopened, -> IDLE. A mismatched ID is ignored.
- Claim read in IDLE or SERVICE: returns best_id, clears that pending bit, no FSM change. Reads are only counted as claims when reg_re=1.
- Same-cycle events:
  - Claim-clear and new edge on the same source: set wins, pending stays 1. Only possible for a source not being claimed.
  - Complete and a new candidate in the same cycle: next notify starts the following cycle at the earliest.
- Level source still high at completion: pending re-sets 1 cycle after complete.
- Nesting: e_intr_o is never re-asserted while in WAIT_CLAIM or SERVICE, except under the optional feature.
- Reset asserted mid-operation clears everything immediately, including any e_intr_o pulse in flight.

Optional Feature:
- Macro: INTR_TIMEOUT_EN.
- Defined: a counter runs in WAIT_CLAIM. After TIMEOUT_CYC cycles with no claim, the FSM returns to NOTIFY and pulses e_intr_o again. The counter clears on each state entry.
- Undefined: no counter is built; WAIT_CLAIM waits indefinitely.

Test Plan:
- Edge notify and claim: PRIORITY[3]=2, ENABLE=0x08, threshold 0, mie_i=1; pulse src_i[3].
  - e_intr_o high exactly one cycle, 4 cycles after the edge.
  - Read 0x0C returns 3; PENDING=0; claim_id_o=3.
  - Write 3 to 0x0C: claim_id_o=0.
- Priority and tie-break: sources 2 and 5 at priority 4, source 6 at priority 5, all raised together.
  - Claims return 6, then 2, then 5, each following a complete.
- Threshold and mask: THRESHOLD=4, source 1 at priority 4, source 1 raised → no e_intr_o.
  - Set THRESHOLD=3 → notify.
  - With mie_i=0, still no notify until mie_i=1.
- Level re-trigger: EDGE[2]=0, src_i[2] held high; claim 2, complete 2.
  - PENDING[2] back to 1 one cycle after complete; second e_intr_o pulse follows.
- Gateway and bad complete: while source 3 is in service, pulse src_i[3] → PENDING[3] stays 0.
  - Write 5 to 0x0C → ignored, claim_id_o=3.
  - Async reset mid-SERVICE → all outputs 0.
- INTR_TIMEOUT_EN with TIMEOUT_CYC=16: notify with no claim → second e_intr_o pulse 17 cycles after the first.
  - Without the macro: no second pulse.
